rtc_bus_ctrl: RTL and testbench
===============================

# rtc_bus_ctrl

Bus-cycle generator between the RTC control logic and the external RTC chip's multiplexed address/data bus. Accepts one-cycle read or write requests carrying an 8-bit register address and an 8-bit data byte. Runs a fixed five-phase bus cycle on AD/CS/RD/RW with the shared bidirectional Dato_sal bus. Returns read data with a one-cycle done pulse.

## Interface
- PHASE_CYC, 4: clock cycles per bus phase; legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_wr  in  1  write request; sampled only while busy=0.
- req_rd  in  1  read request; sampled only while busy=0.
- addr  in  8  RTC register address; latched at accept.
- wdata  in  8  write byte; latched at accept.
- busy  out  1  high while a bus cycle is in progress.
- done  out  1  one-cycle pulse at the end of every cycle, read or write.
- rdata  out  8  last byte read; holds until the next read completes.
- AD  out  1  address strobe; 0 = address phase, 1 = data phase.
- CS  out  1  chip select, active-low.
- RD  out  1  read strobe, active-low.
- RW  out  1  write strobe, active-low.
- Dato_sal  inout  8  multiplexed address/data bus; high-Z when not driven.

## Operation
- States: IDLE, ADDR, ADDR_HOLD, DATA, DATA_END, RECOVER. Every non-IDLE state lasts exactly PHASE_CYC cycles, timed by an 8-bit phase counter that reloads on each state change.
- IDLE: AD=1, CS=1, RD=1, RW=1, Dato_sal=Z, busy=0.
- Accept: in IDLE, req_wr or req_rd high at a rising edge latches addr, wdata and direction, then moves to ADDR.
  - req_wr and req_rd high together: write wins.
  - Requests while busy=1 are ignored. They are not queued.
- ADDR: CS=0, AD=0, RD=1, RW=1, Dato_sal drives latched addr.
- ADDR_HOLD: CS=0, AD=1, strobes high, addr still driven (hold time).
- DATA, write: RW=0, RD=1, Dato_sal drives latched wdata.
- DATA, read: RD=0, RW=1, Dato_sal=Z. rdata captures Dato_sal at the clock edge that ends DATA.
- DATA_END: strobes back high and CS=0.
  - Write: wdata stays driven.
  - Read: bus stays Z.
- RECOVER: CS=1, AD=1, strobes high, Dato_sal=Z.
- Exit from RECOVER: return to IDLE with done=1 for one cycle.
- Output enable on Dato_sal is asserted only in ADDR, ADDR_HOLD, and the DATA and DATA_END phases of a write. The bus is never driven while RD=0.
- Reset (rst low, at any time including mid-cycle), applied immediately and without waiting for clk:
  - State goes to IDLE and all bus outputs go to idle values; Dato_sal=Z.
  - busy=0, done=0, rdata=0x00.
  - An aborted cycle produces no done pulse.

## Timing
- Let P = PHASE_CYC and accept edge = E0.
- busy rises at E0 and falls at E0+5P. done is high for the single cycle after E0+5P.
- Phase windows, each P cycles long:
  - ADDR: E0..E0+P
  - ADDR_HOLD: E0+P..E0+2P
  - DATA: E0+2P..E0+3P
  - DATA_END: E0+3P..E0+4P
  - RECOVER: E0+4P..E0+5P
- rdata is valid from E0+3P onward and remains stable through done.
- Back-to-back operation: a request present during the done cycle is accepted, since busy=0 then. Minimum request spacing is 5P+1 cycles.
- P=1 is legal: each phase is one cycle and total latency is 5 cycles.
- All outputs are registered, with no combinational path from request inputs to bus pins.

## Test plan
- Reset: hold rst=0 for 10 cycles, then release. Required: AD=CS=RD=RW=1, Dato_sal=Z, busy=0, done=0, rdata=0x00.
- Write, P=4: req_wr with addr=0x21 and wdata=0x59. Required:
  - Cycles 1–4: AD=0, CS=0, bus=0x21.
  - Cycles 5–8: AD=1, bus=0x21.
  - Cycles 9–12: RW=0, bus=0x59.
  - Cycles 13–16: RW=1, CS=0, bus=0x59.
  - Cycles 17–20: CS=1, bus=Z.
  - done pulses at cycle 21.
- Read, P=4: req_rd with addr=0x04; bench model drives 0x37 while RD=0. Required:
  - RD=0 in cycles 9–12 and Dato_sal not driven by the DUT.
  - rdata=0x37 from cycle 13.
  - done pulses at cycle 21.
- Collisions: req_wr and req_rd together, then req_rd pulsed at cycle 6. Required: a single write cycle runs, RD never goes low, and exactly one done pulse occurs.
- Reset mid-operation: assert rst=0 during the DATA phase of a write. Required: CS=1, RW=1 and bus=Z immediately without a clock edge, no done pulse, busy=0.
- Back-to-back with P=1: a write, then a read requested during the write's done cycle. Required: the read is accepted at that edge, with done pulses 6 cycles apart.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle generator for an external RTC chip on a multiplexed address/data bus.
// Each request runs five fixed-length phases: ADDR, ADDR_HOLD, DATA, DATA_END, RECOVER.
module rtc_bus_ctrl #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       RW,
  inout  wire  [7:0] Dato_sal
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_HOLD,
    DATA,
    DATA_END,
    RECOVER
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ad_q, ad_d;
  logic       cs_q, cs_d;
  logic       rd_q, rd_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       phase_end;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    phase_end = (cnt_q == PHASE_LAST);

    if (state_q == IDLE) begin
      if (req_wr || req_rd) begin
        state_d = ADDR;
        cnt_d   = 8'd0;
        addr_d  = addr;
        wdata_d = wdata;
        wr_d    = req_wr;
      end
    end else if (phase_end) begin
      cnt_d = 8'd0;
      case (state_q)
        ADDR:      state_d = ADDR_HOLD;
        ADDR_HOLD: state_d = DATA;
        DATA: begin
          state_d = DATA_END;
          // The chip still drives the bus here: RD only rises after this edge.
          if (!wr_q) rdata_d = Dato_sal;
        end
        DATA_END:  state_d = RECOVER;
        RECOVER: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default:   state_d = IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // Pin values are decoded from the next state so every pin comes straight off a flop.
    ad_d   = 1'b1;
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    rw_d   = 1'b1;
    oe_d   = 1'b0;
    dout_d = addr_d;
    busy_d = (state_d != IDLE);
    case (state_d)
      ADDR: begin
        cs_d = 1'b0;
        ad_d = 1'b0;
        oe_d = 1'b1;
      end
      ADDR_HOLD: begin
        cs_d = 1'b0;
        oe_d = 1'b1;
      end
      DATA: begin
        cs_d   = 1'b0;
        dout_d = wdata_d;
        if (wr_d) begin
          rw_d = 1'b0;
          oe_d = 1'b1;
        end else begin
          rd_d = 1'b0;
        end
      end
      DATA_END: begin
        cs_d   = 1'b0;
        dout_d = wdata_d;
        oe_d   = wr_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ad_q    <= ad_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
    end
  end

  // Latched transfer data is gated by oe_q, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    dout_q  <= dout_d;
  end

  assign Dato_sal = oe_q ? dout_q : 8'hzz;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign AD       = ad_q;
  assign CS       = cs_q;
  assign RD       = rd_q;
  assign RW       = rw_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: one instance with 4-cycle phases, one with 1-cycle phases.
module tb_rtc_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       req_wr4 = 1'b0, req_rd4 = 1'b0;
  logic [7:0] addr4 = 8'h00, wdata4 = 8'h00;
  logic       busy4, done4, ad4, cs4, rd4, rw4;
  logic [7:0] rdata4;
  wire  [7:0] bus4;

  logic       req_wr1 = 1'b0, req_rd1 = 1'b0;
  logic [7:0] addr1 = 8'h00, wdata1 = 8'h00;
  logic       busy1, done1, ad1, cs1, rd1, rw1;
  logic [7:0] rdata1;
  wire  [7:0] bus1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // RTC chip model: answers a read only while RD is asserted.
  assign bus4 = (!rd4) ? 8'h37 : 8'hzz;
  assign bus1 = (!rd1) ? 8'h6B : 8'hzz;

  rtc_bus_ctrl #(.PHASE_CYC(4)) u_p4 (
    .clk(clk), .rst(rst), .req_wr(req_wr4), .req_rd(req_rd4),
    .addr(addr4), .wdata(wdata4), .busy(busy4), .done(done4), .rdata(rdata4),
    .AD(ad4), .CS(cs4), .RD(rd4), .RW(rw4), .Dato_sal(bus4)
  );

  rtc_bus_ctrl #(.PHASE_CYC(1)) u_p1 (
    .clk(clk), .rst(rst), .req_wr(req_wr1), .req_rd(req_rd1),
    .addr(addr1), .wdata(wdata1), .busy(busy1), .done(done1), .rdata(rdata1),
    .AD(ad1), .CS(cs1), .RD(rd1), .RW(rw1), .Dato_sal(bus1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int phase;
    int ndone;
    int first_done;
    int second_done;
    logic rd_seen;
    logic rw_seen;

    // Reset
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ad", ad4, 1'b1);
    chk("rst_cs", cs4, 1'b1);
    chk("rst_rd", rd4, 1'b1);
    chk("rst_rw", rw4, 1'b1);
    chk("rst_oe", u_p4.oe_q, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_rdata", rdata4, 8'h00);
    chk("rst_p1_busy", busy1, 1'b0);
    chk("rst_p1_cs", cs1, 1'b1);

    // Write, P=4
    addr4 = 8'h21; wdata4 = 8'h59; req_wr4 = 1'b1;
    @(posedge clk); #1;
    req_wr4 = 1'b0; addr4 = 8'hFF; wdata4 = 8'hEE;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k <= 20) begin
        phase = (k - 1) / 4;
        chk($sformatf("wr_cs_c%0d", k), cs4, (phase < 4) ? 1'b0 : 1'b1);
        chk($sformatf("wr_ad_c%0d", k), ad4, (phase == 0) ? 1'b0 : 1'b1);
        chk($sformatf("wr_rw_c%0d", k), rw4, (phase == 2) ? 1'b0 : 1'b1);
        chk($sformatf("wr_rd_c%0d", k), rd4, 1'b1);
        chk($sformatf("wr_oe_c%0d", k), u_p4.oe_q, (phase < 4) ? 1'b1 : 1'b0);
        if (phase < 2) chk($sformatf("wr_bus_c%0d", k), bus4, 8'h21);
        else if (phase < 4) chk($sformatf("wr_bus_c%0d", k), bus4, 8'h59);
        chk($sformatf("wr_busy_c%0d", k), busy4, 1'b1);
        chk($sformatf("wr_done_c%0d", k), done4, 1'b0);
      end else begin
        chk("wr_done_c21", done4, 1'b1);
        chk("wr_busy_c21", busy4, 1'b0);
        chk("wr_cs_c21", cs4, 1'b1);
      end
    end
    @(negedge clk);
    chk("wr_done_c22", done4, 1'b0);

    // Read, P=4
    addr4 = 8'h04; req_rd4 = 1'b1;
    @(posedge clk); #1;
    req_rd4 = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) chk("rd_bus_addr", bus4, 8'h04);
      if (k >= 9 && k <= 12) begin
        chk($sformatf("rd_rd_c%0d", k), rd4, 1'b0);
        chk($sformatf("rd_oe_c%0d", k), u_p4.oe_q, 1'b0);
        chk($sformatf("rd_bus_c%0d", k), bus4, 8'h37);
        chk($sformatf("rd_rw_c%0d", k), rw4, 1'b1);
      end else begin
        chk($sformatf("rd_rdhi_c%0d", k), rd4, 1'b1);
      end
      if (k == 12) chk("rd_rdata_c12", rdata4, 8'h00);
      if (k >= 13) chk($sformatf("rd_rdata_c%0d", k), rdata4, 8'h37);
      if (k >= 13 && k <= 16) chk($sformatf("rd_oe_c%0d", k), u_p4.oe_q, 1'b0);
      chk($sformatf("rd_done_c%0d", k), done4, (k == 21) ? 1'b1 : 1'b0);
    end

    // Collision: simultaneous request resolves to a write; mid-cycle read is dropped
    addr4 = 8'h10; wdata4 = 8'hA0; req_wr4 = 1'b1; req_rd4 = 1'b1;
    @(posedge clk); #1;
    req_wr4 = 1'b0; req_rd4 = 1'b0;
    ndone = 0; rd_seen = 1'b0; rw_seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 6) req_rd4 = 1'b1;
      if (k == 7) req_rd4 = 1'b0;
      if (k == 10) chk("col_bus_wdata", bus4, 8'hA0);
      if (done4) ndone++;
      if (!rd4) rd_seen = 1'b1;
      if (!rw4) rw_seen = 1'b1;
    end
    chk("col_done_count", 8'(ndone), 8'd1);
    chk("col_rd_low", rd_seen, 1'b0);
    chk("col_rw_low", rw_seen, 1'b1);
    chk("col_rdata_kept", rdata4, 8'h37);

    // Back-to-back, P=1
    addr1 = 8'h33; wdata1 = 8'hC4; req_wr1 = 1'b1;
    @(posedge clk); #1;
    req_wr1 = 1'b0;
    ndone = 0; first_done = 0; second_done = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("b2b_ad_c1", ad1, 1'b0);
        chk("b2b_bus_c1", bus1, 8'h33);
      end
      if (k == 3) begin
        chk("b2b_rw_c3", rw1, 1'b0);
        chk("b2b_bus_c3", bus1, 8'hC4);
      end
      if (k == 5) chk("b2b_cs_c5", cs1, 1'b1);
      if (k == 6) chk("b2b_busy_c6", busy1, 1'b0);
      if (done1) begin
        ndone++;
        if (ndone == 1) first_done = k;
        if (ndone == 2) second_done = k;
      end
      if (k == 6) begin
        addr1 = 8'h0A; req_rd1 = 1'b1;
      end
      if (k == 7) begin
        req_rd1 = 1'b0;
        chk("b2b_accept_busy", busy1, 1'b1);
        chk("b2b_accept_ad", ad1, 1'b0);
      end
      if (k == 9) chk("b2b_rd_c9", rd1, 1'b0);
      if (k == 12) chk("b2b_rdata", rdata1, 8'h6B);
    end
    chk("b2b_done_count", 8'(ndone), 8'd2);
    chk("b2b_first_done", 8'(first_done), 8'd6);
    chk("b2b_done_spacing", 8'(second_done - first_done), 8'd6);

    // Reset in the DATA phase of a write
    addr4 = 8'h5E; wdata4 = 8'h77; req_wr4 = 1'b1;
    @(posedge clk); #1;
    req_wr4 = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rw_before", rw4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_cs", cs4, 1'b1);
    chk("mid_rw", rw4, 1'b1);
    chk("mid_ad", ad4, 1'b1);
    chk("mid_oe", u_p4.oe_q, 1'b0);
    chk("mid_busy", busy4, 1'b0);
    chk("mid_done", done4, 1'b0);
    chk("mid_rdata", rdata4, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("mid_no_done", 8'(ndone), 8'd0);
    chk("mid_idle_busy", busy4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
